// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the UART core: parity-mode encodings,
//                FSM state encodings (used by both RX and TX) and the
//                oversampling factor.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Baud ticks per serial bit
    localparam int c_oversample = 16;

    // parity_mode encodings; 2'b11 is treated as no parity
    localparam logic [1:0] c_par_none = 2'b00;
    localparam logic [1:0] c_par_even = 2'b01;
    localparam logic [1:0] c_par_odd  = 2'b10;

    // FSM state encodings shared by RX and TX
    typedef logic [2:0] uart_state_t;
    localparam uart_state_t c_st_idle   = 3'd0;
    localparam uart_state_t c_st_start  = 3'd1;
    localparam uart_state_t c_st_data   = 3'd2;
    localparam uart_state_t c_st_parity = 3'd3;
    localparam uart_state_t c_st_stop   = 3'd4;

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == c_par_even) || (mode == c_par_odd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous first-word-fall-through FIFO, depth 2**FIFO_W.
//                Extra pointer MSB distinguishes full from empty.
//  Ports       : clk, reset (async, active-high)
//                i_wr / i_w_data  - push (ignored when full unless popping)
//                i_rd             - pop (ignored when empty)
//                o_r_data         - head word (0 while empty)
//                o_full / o_empty - status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_wr,
    input  logic            i_rd,
    input  logic [DBIT-1:0] i_w_data,
    output logic [DBIT-1:0] o_r_data,
    output logic            o_full,
    output logic            o_empty
);

    localparam int c_depth = 2 ** FIFO_W;

    logic [DBIT-1:0] r_mem [0:c_depth-1];
    logic [FIFO_W:0] r_wr_ptr;
    logic [FIFO_W:0] r_rd_ptr;
    logic            w_do_wr;
    logic            w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[FIFO_W] != r_rd_ptr[FIFO_W]) &&
                     (r_wr_ptr[FIFO_W-1:0] == r_rd_ptr[FIFO_W-1:0]);

    // A pop frees the slot being written when full, so both may proceed.
    assign w_do_wr = i_wr && (!o_full || i_rd);
    assign w_do_rd = i_rd && !o_empty;

    assign o_r_data = o_empty ? '0 : r_mem[r_rd_ptr[FIFO_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[FIFO_W-1:0]] <= i_w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core
//  Description : UART with runtime baud divisor, optional even/odd parity,
//                16x oversampled receiver and TX/RX FIFOs with sticky errors.
//  Ports       : clk, reset (async, active-high)
//                rx / tx            - serial lines, idle high
//                dvsr               - tick period = dvsr+1 clocks
//                parity_mode        - 00 none, 01 even, 10 odd, 11 none
//                wr_uart, w_data    - TX FIFO push;  tx_full, tx_idle status
//                rd_uart, r_data    - RX FIFO pop/head; rx_empty status
//                parity_err, frame_err, overrun_err - sticky, clr_err clears
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_core
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic                tx,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          parity_mode,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic                tx_idle,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                rx_empty,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun_err,
    input  logic                clr_err
);

    localparam int c_sw = (SB_TICK > c_oversample) ? $clog2(SB_TICK) : $clog2(c_oversample);
    localparam logic [c_sw-1:0] c_s_mid      = c_sw'(c_oversample / 2 - 1);
    localparam logic [c_sw-1:0] c_s_bit_end  = c_sw'(c_oversample - 1);
    localparam logic [c_sw-1:0] c_s_stop_end = c_sw'(SB_TICK - 1);
    localparam logic [2:0]      c_n_last     = 3'(DBIT - 1);

    // ---------------- baud generator ----------------
    // ">=" lets a shrinking dvsr take effect without running past the wrap.
    logic [DVSR_BIT-1:0] r_baud_cnt;
    logic                w_tick;

    assign w_tick = (r_baud_cnt >= dvsr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_baud_cnt <= '0;
        else if (w_tick) r_baud_cnt <= '0;
        else             r_baud_cnt <= r_baud_cnt + 1'b1;
    end

    // ---------------- rx synchroniser ----------------
    logic r_rx_sync1;
    logic r_rx_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
        end else begin
            r_rx_sync1 <= rx;
            r_rx_sync2 <= r_rx_sync1;
        end
    end

    // ---------------- receiver FSM ----------------
    uart_state_t     r_rx_state, w_rx_state_nx;
    logic [c_sw-1:0] r_rx_s, w_rx_s_nx;
    logic [2:0]      r_rx_n, w_rx_n_nx;
    logic [DBIT-1:0] r_rx_b, w_rx_b_nx;
    logic [1:0]      r_rx_pmode, w_rx_pmode_nx;
    logic            r_rx_par_bad, w_rx_par_bad_nx;
    logic            w_rx_done;
    logic            w_frame_evt;
    logic            w_rx_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state   <= c_st_idle;
            r_rx_s       <= '0;
            r_rx_n       <= '0;
            r_rx_b       <= '0;
            r_rx_pmode   <= c_par_none;
            r_rx_par_bad <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nx;
            r_rx_s       <= w_rx_s_nx;
            r_rx_n       <= w_rx_n_nx;
            r_rx_b       <= w_rx_b_nx;
            r_rx_pmode   <= w_rx_pmode_nx;
            r_rx_par_bad <= w_rx_par_bad_nx;
        end
    end

    always_comb begin
        w_rx_state_nx   = r_rx_state;
        w_rx_s_nx       = r_rx_s;
        w_rx_n_nx       = r_rx_n;
        w_rx_b_nx       = r_rx_b;
        w_rx_pmode_nx   = r_rx_pmode;
        w_rx_par_bad_nx = r_rx_par_bad;
        w_rx_done       = 1'b0;
        w_frame_evt     = 1'b0;
        case (r_rx_state)
            c_st_idle: begin
                if (!r_rx_sync2) begin
                    w_rx_state_nx = c_st_start;
                    w_rx_s_nx     = '0;
                    w_rx_pmode_nx = parity_mode;
                end
            end
            c_st_start: begin
                if (w_tick) begin
                    if (r_rx_s == c_s_mid) begin
                        // Mid-start re-check filters glitches on the line
                        if (!r_rx_sync2) begin
                            w_rx_state_nx   = c_st_data;
                            w_rx_s_nx       = '0;
                            w_rx_n_nx       = '0;
                            w_rx_par_bad_nx = 1'b0;
                        end else begin
                            w_rx_state_nx = c_st_idle;
                        end
                    end else begin
                        w_rx_s_nx = r_rx_s + 1'b1;
                    end
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    if (r_rx_s == c_s_bit_end) begin
                        w_rx_s_nx = '0;
                        w_rx_b_nx = {r_rx_sync2, r_rx_b[DBIT-1:1]};
                        if (r_rx_n == c_n_last) begin
                            w_rx_state_nx = parity_enabled(r_rx_pmode) ? c_st_parity : c_st_stop;
                        end else begin
                            w_rx_n_nx = r_rx_n + 1'b1;
                        end
                    end else begin
                        w_rx_s_nx = r_rx_s + 1'b1;
                    end
                end
            end
            c_st_parity: begin
                if (w_tick) begin
                    if (r_rx_s == c_s_bit_end) begin
                        w_rx_s_nx       = '0;
                        w_rx_par_bad_nx = ((^r_rx_b) ^ r_rx_sync2) != (r_rx_pmode == c_par_odd);
                        w_rx_state_nx   = c_st_stop;
                    end else begin
                        w_rx_s_nx = r_rx_s + 1'b1;
                    end
                end
            end
            c_st_stop: begin
                if (w_tick) begin
                    if (r_rx_s == c_s_stop_end) begin
                        w_rx_state_nx = c_st_idle;
                        w_rx_done     = 1'b1;
                        w_frame_evt   = !r_rx_sync2;
                    end else begin
                        w_rx_s_nx = r_rx_s + 1'b1;
                    end
                end
            end
            default: w_rx_state_nx = c_st_idle;
        endcase
    end

    uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_wr     (w_rx_done),
        .i_rd     (rd_uart),
        .i_w_data (r_rx_b),
        .o_r_data (r_data),
        .o_full   (w_rx_full),
        .o_empty  (rx_empty)
    );

    // ---------------- sticky error flags (set beats clear) ----------------
    logic w_overrun_evt;
    logic r_parity_err, r_frame_err, r_overrun_err;

    assign w_overrun_evt = w_rx_done && w_rx_full && !rd_uart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_rx_done && r_rx_par_bad) r_parity_err <= 1'b1;
            else if (clr_err)              r_parity_err <= 1'b0;
            if (w_frame_evt)               r_frame_err <= 1'b1;
            else if (clr_err)              r_frame_err <= 1'b0;
            if (w_overrun_evt)             r_overrun_err <= 1'b1;
            else if (clr_err)              r_overrun_err <= 1'b0;
        end
    end

    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

    // ---------------- transmitter FSM ----------------
    uart_state_t     r_tx_state, w_tx_state_nx;
    logic [c_sw-1:0] r_tx_s, w_tx_s_nx;
    logic [2:0]      r_tx_n, w_tx_n_nx;
    logic [DBIT-1:0] r_tx_b, w_tx_b_nx;
    logic            r_tx_par, w_tx_par_nx;
    logic            r_tx_pen, w_tx_pen_nx;
    logic            r_tx, w_tx_nx;
    logic            r_tx_avail;
    logic            w_tx_pop;
    logic            w_tx_empty;
    logic [DBIT-1:0] w_tx_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_st_idle;
            r_tx_s     <= '0;
            r_tx_n     <= '0;
            r_tx_b     <= '0;
            r_tx_par   <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_avail <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_s     <= w_tx_s_nx;
            r_tx_n     <= w_tx_n_nx;
            r_tx_b     <= w_tx_b_nx;
            r_tx_par   <= w_tx_par_nx;
            r_tx_pen   <= w_tx_pen_nx;
            r_tx       <= w_tx_nx;
            r_tx_avail <= !w_tx_empty;
        end
    end

    // From idle, a frame starts only once the FIFO has been non-empty for a
    // full cycle, giving a fixed two-edge write-to-start-bit latency.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_s_nx     = r_tx_s;
        w_tx_n_nx     = r_tx_n;
        w_tx_b_nx     = r_tx_b;
        w_tx_par_nx   = r_tx_par;
        w_tx_pen_nx   = r_tx_pen;
        w_tx_nx       = r_tx;
        w_tx_pop      = 1'b0;
        case (r_tx_state)
            c_st_idle: begin
                w_tx_nx = 1'b1;
                if (r_tx_avail && !w_tx_empty) w_tx_pop = 1'b1;
            end
            c_st_start: begin
                if (w_tick) begin
                    if (r_tx_s == c_s_bit_end) begin
                        w_tx_state_nx = c_st_data;
                        w_tx_s_nx     = '0;
                        w_tx_n_nx     = '0;
                        w_tx_nx       = r_tx_b[0];
                    end else begin
                        w_tx_s_nx = r_tx_s + 1'b1;
                    end
                end
            end
            c_st_data: begin
                if (w_tick) begin
                    if (r_tx_s == c_s_bit_end) begin
                        w_tx_s_nx = '0;
                        w_tx_b_nx = {1'b0, r_tx_b[DBIT-1:1]};
                        if (r_tx_n == c_n_last) begin
                            w_tx_state_nx = r_tx_pen ? c_st_parity : c_st_stop;
                            w_tx_nx       = r_tx_pen ? r_tx_par : 1'b1;
                        end else begin
                            w_tx_n_nx = r_tx_n + 1'b1;
                            w_tx_nx   = r_tx_b[1];
                        end
                    end else begin
                        w_tx_s_nx = r_tx_s + 1'b1;
                    end
                end
            end
            c_st_parity: begin
                if (w_tick) begin
                    if (r_tx_s == c_s_bit_end) begin
                        w_tx_state_nx = c_st_stop;
                        w_tx_s_nx     = '0;
                        w_tx_nx       = 1'b1;
                    end else begin
                        w_tx_s_nx = r_tx_s + 1'b1;
                    end
                end
            end
            c_st_stop: begin
                if (w_tick) begin
                    if (r_tx_s == c_s_stop_end) begin
                        if (!w_tx_empty) w_tx_pop = 1'b1;  // back-to-back frame
                        else             w_tx_state_nx = c_st_idle;
                    end else begin
                        w_tx_s_nx = r_tx_s + 1'b1;
                    end
                end
            end
            default: begin
                w_tx_state_nx = c_st_idle;
                w_tx_nx       = 1'b1;
            end
        endcase
        // Frame load: data and parity settings are frozen for the whole frame
        if (w_tx_pop) begin
            w_tx_state_nx = c_st_start;
            w_tx_s_nx     = '0;
            w_tx_b_nx     = w_tx_head;
            w_tx_par_nx   = (^w_tx_head) ^ (parity_mode == c_par_odd);
            w_tx_pen_nx   = parity_enabled(parity_mode);
            w_tx_nx       = 1'b0;
        end
    end

    uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_wr     (wr_uart),
        .i_rd     (w_tx_pop),
        .i_w_data (w_data),
        .o_r_data (w_tx_head),
        .o_full   (tx_full),
        .o_empty  (w_tx_empty)
    );

    assign tx      = r_tx;
    assign tx_idle = (r_tx_state == c_st_idle) && w_tx_empty;

endmodule
`default_nettype wire
